// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
// Optional RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking in ram_arb_picker.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_t;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam int MAX_WAIT_CYCLES = 15;

    // Wait counter never shrinks below one bit, even with zero wait states.
    function automatic int waitCntWidth(input int waitCycles);
        return (waitCycles < 1) ? 1 : $clog2(waitCycles + 1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both master request ports and the RAM-side port of the arbiter.
// master = requesters plus RAM model side, slave = the arbiter itself.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_done;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_done;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wd;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic                  busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_rd,
        input  m0_gnt, m0_done, m0_rdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  ram_we, ram_addr, ram_wd, busy
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_rd,
        output m0_gnt, m0_done, m0_rdata,
        output m1_gnt, m1_done, m1_rdata,
        output ram_we, ram_addr, ram_wd, busy
    );
endinterface

// File: rtl/ram_port_arbiter_picker.sv
// Winner selection between the two masters for the RAM port arbiter.
// RAM_ARB_ROUND_ROBIN_EN: alternate on ties; otherwise m0 has fixed priority.
module ram_arb_picker
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic winner
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic lastWinner;

    // Reset to m1 so that m0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastWinner <= MASTER_M1;
        end else if (take) begin
            lastWinner <= winner;
        end
    end

    always_comb begin
        winner = MASTER_M0;
        if (req0 && req1) begin
            winner = ~lastWinner;
        end else if (req1) begin
            winner = MASTER_M1;
        end
    end
`else
    logic unusedInputs;
    assign unusedInputs = clk ^ rst ^ take;

    always_comb begin
        winner = (req1 && !req0) ? MASTER_M1 : MASTER_M0;
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises two masters onto the single-port data RAM with WAIT_CYCLES extra hold cycles.
// Tie-break policy is chosen by RAM_ARB_ROUND_ROBIN_EN (see ram_arb_picker).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 0
) (
    input logic clk,
    input logic rst,
    ram_port_arbiter_if.slave bus
);

    localparam int CNT_W = waitCntWidth(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    arb_state_t state, stateNext;
    logic [CNT_W-1:0]      waitCnt;
    logic                  latchedWe;
    logic [ADDR_WIDTH-1:0] latchedAddr;
    logic [DATA_WIDTH-1:0] latchedWdata;
    logic                  owner;
    logic                  firstCycle;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  winner;
    logic                  take;
    logic                  accessEnd;

    assign take      = (state == ARB_IDLE) && (bus.m0_req || bus.m1_req);
    assign accessEnd = (state == ARB_ACCESS) && (waitCnt == '0);

    ram_arb_picker uPicker (
        .clk    (clk),
        .rst    (rst),
        .req0   (bus.m0_req),
        .req1   (bus.m1_req),
        .take   (take),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ARB_IDLE:   if (take) stateNext = ARB_ACCESS;
            ARB_ACCESS: if (waitCnt == '0) stateNext = ARB_DONE;
            ARB_DONE:   stateNext = ARB_IDLE;
            default:    stateNext = ARB_IDLE;
        endcase
    end

    // Winner's request is captured on acceptance so the master may drop it after gnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt      <= '0;
            latchedWe    <= 1'b0;
            latchedAddr  <= '0;
            latchedWdata <= '0;
            owner        <= MASTER_M0;
            firstCycle   <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            firstCycle <= take;
            if (take) begin
                owner        <= winner;
                latchedWe    <= (winner == MASTER_M1) ? bus.m1_we    : bus.m0_we;
                latchedAddr  <= (winner == MASTER_M1) ? bus.m1_addr  : bus.m0_addr;
                latchedWdata <= (winner == MASTER_M1) ? bus.m1_wdata : bus.m0_wdata;
                waitCnt      <= WAIT_LOAD;
            end else if ((state == ARB_ACCESS) && (waitCnt != '0)) begin
                waitCnt <= waitCnt - 1'b1;
            end
            if (accessEnd && !latchedWe) begin
                if (owner == MASTER_M1) begin
                    rdata1 <= bus.ram_rd;
                end else begin
                    rdata0 <= bus.ram_rd;
                end
            end
        end
    end

    // Write strobe only in the final ACCESS cycle, so the RAM sees one write per access.
    always_comb begin
        bus.m0_gnt   = 1'b0;
        bus.m1_gnt   = 1'b0;
        bus.m0_done  = 1'b0;
        bus.m1_done  = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_wd   = '0;
        if (state == ARB_ACCESS) begin
            bus.ram_addr = latchedAddr;
            bus.ram_wd   = latchedWdata;
            bus.ram_we   = latchedWe && (waitCnt == '0);
            if (firstCycle) begin
                bus.m0_gnt = (owner == MASTER_M0);
                bus.m1_gnt = (owner == MASTER_M1);
            end
        end
        if (state == ARB_DONE) begin
            bus.m0_done = (owner == MASTER_M0);
            bus.m1_done = (owner == MASTER_M1);
        end
    end

    assign bus.busy     = (state != ARB_IDLE);
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: directed steps on WAIT_CYCLES=0 and 3 instances, then a randomized
// run of the WAIT_CYCLES=3 instance against a transaction-level timeline model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int WB = 3;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busA ();
    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busB ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(WB)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    // Combinational-read RAMs standing in for RAM_Single_Port.
    logic [31:0] memA [256] = '{default: 32'h0};
    logic [31:0] memB [256] = '{default: 32'h0};
    assign busA.ram_rd = memA[busA.ram_addr[7:0]];
    assign busB.ram_rd = memB[busB.ram_addr[7:0]];
    always @(posedge clk) begin
        if (busA.ram_we) memA[busA.ram_addr[7:0]] <= busA.ram_wd;
        if (busB.ram_we) memB[busB.ram_addr[7:0]] <= busB.ram_wd;
    end

    // Flag order: m0_gnt, m1_gnt, m0_done, m1_done, busy, ram_we.
    logic [5:0] flagsA, flagsB;
    assign flagsA = {busA.m0_gnt, busA.m1_gnt, busA.m0_done, busA.m1_done, busA.busy, busA.ram_we};
    assign flagsB = {busB.m0_gnt, busB.m1_gnt, busB.m0_done, busB.m1_done, busB.busy, busB.ram_we};

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit useB, input int m, input bit req, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wd);
        if (!useB && m == 0) begin
            busA.m0_req = req; busA.m0_we = we; busA.m0_addr = addr; busA.m0_wdata = wd;
        end else if (!useB) begin
            busA.m1_req = req; busA.m1_we = we; busA.m1_addr = addr; busA.m1_wdata = wd;
        end else if (m == 0) begin
            busB.m0_req = req; busB.m0_we = we; busB.m0_addr = addr; busB.m0_wdata = wd;
        end else begin
            busB.m1_req = req; busB.m1_we = we; busB.m1_addr = addr; busB.m1_wdata = wd;
        end
    endtask

    task automatic clearInputs();
        for (int u = 0; u < 2; u++) begin
            for (int m = 0; m < 2; m++) applyStimulus(u[0], m, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic pulseReset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Random-phase model state: a timeline of accepted transactions, not an FSM.
    int          startEdge, freeEdge, off;
    bit          lastW, curOwner, curWe, active, w;
    logic [31:0] curAddr, curWd;
    bit          pend [2];
    bit          pWe [2];
    logic [31:0] pAddr [2];
    logic [31:0] pWd [2];
    logic [31:0] modelMem [256];
    logic [31:0] modelRd [2];
    logic [5:0]  expFlags;
    logic [5:0]  t3Flags [6];
    bit          ownerOf;

    initial begin
        clearInputs();
        tick();
        tick();
        checkOutput("resetA.flags", 32'(flagsA), 32'h0);
        checkOutput("resetB.flags", 32'(flagsB), 32'h0);
        checkOutput("resetA.addr", busA.ram_addr, 32'h0);
        checkOutput("resetA.rdata0", busA.m0_rdata, 32'h0);
        checkOutput("resetB.rdata1", busB.m1_rdata, 32'h0);
        rst = 1'b0;

        // m0 write then read-back with zero wait states.
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        checkOutput("t1.wr.gnt_we", 32'(flagsA), 32'(6'b100011));
        checkOutput("t1.wr.addr", busA.ram_addr, 32'h10);
        checkOutput("t1.wr.wd", busA.ram_wd, 32'hDEADBEEF);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t1.wr.done", 32'(flagsA), 32'(6'b001010));
        checkOutput("t1.wr.mem", memA[16], 32'hDEADBEEF);
        tick();
        checkOutput("t1.wr.idle", 32'(flagsA), 32'h0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        checkOutput("t1.rd.gnt", 32'(flagsA), 32'(6'b100010));
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t1.rd.done", 32'(flagsA), 32'(6'b001010));
        checkOutput("t1.rd.rdata", busA.m0_rdata, 32'hDEADBEEF);
        tick();
        checkOutput("t1.rd.idle", 32'(flagsA), 32'h0);

        // m1 raised while m0 is in ACCESS must wait for the next IDLE.
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        checkOutput("t4.m0gnt", 32'(flagsA), 32'(6'b100010));
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        tick();
        checkOutput("t4.m0done", 32'(flagsA), 32'(6'b001010));
        tick();
        checkOutput("t4.idleGap", 32'(flagsA), 32'h0);
        tick();
        checkOutput("t4.m1gnt", 32'(flagsA), 32'(6'b010011));
        checkOutput("t4.m1addr", busA.ram_addr, 32'h20);
        applyStimulus(1'b0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t4.m1done", 32'(flagsA), 32'(6'b000110));
        checkOutput("t4.m0rdataKept", busA.m0_rdata, 32'hDEADBEEF);
        checkOutput("t4.m1rdataKept", busA.m1_rdata, 32'h0);
        tick();

        // Both masters reading continuously from reset.
        pulseReset();
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 1, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int c = 0; c < 12; c++) begin
            tick();
            ownerOf = RR ? 1'((c / 3) % 2) : 1'b0;
            expFlags = 6'b0;
            if (c % 3 == 0) expFlags = ownerOf ? 6'b010010 : 6'b100010;
            if (c % 3 == 1) expFlags = ownerOf ? 6'b000110 : 6'b001010;
            checkOutput($sformatf("t2.c%0d", c), 32'(flagsA), 32'(expFlags));
        end
        clearInputs();
        checkOutput("t2.m0rdata", busA.m0_rdata, 32'hDEADBEEF);
        checkOutput("t2.m1rdata", busA.m1_rdata, RR ? 32'h12345678 : 32'h0);
        tick();

        // Quiet bus stays quiet.
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput($sformatf("t6.c%0d", c), 32'(flagsA), 32'h0);
        end

        // Three wait states: m1 write held four ACCESS cycles, strobe in the last.
        t3Flags[0] = 6'b010010;
        t3Flags[1] = 6'b000010;
        t3Flags[2] = 6'b000010;
        t3Flags[3] = 6'b000011;
        t3Flags[4] = 6'b000110;
        t3Flags[5] = 6'b000000;
        applyStimulus(1'b1, 1, 1'b1, 1'b1, 32'h30, 32'h55);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) applyStimulus(1'b1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("t3.c%0d", c), 32'(flagsB), 32'(t3Flags[c]));
            checkOutput($sformatf("t3.addr%0d", c), busB.ram_addr, (c < 4) ? 32'h30 : 32'h0);
        end
        checkOutput("t3.mem", memB[8'h30], 32'h55);

        // Asynchronous reset in the middle of a waited write.
        applyStimulus(1'b1, 0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
        tick();
        checkOutput("t5.gnt", 32'(flagsB), 32'(6'b100010));
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("t5.asyncFlags", 32'(flagsB), 32'h0);
        checkOutput("t5.asyncAddr", busB.ram_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("t5.post%0d", c), 32'(flagsB), 32'h0);
        end
        checkOutput("t5.memUntouched", memB[8'h40], 32'h0);

        // Randomized traffic on the waited instance, checked against the timeline model.
        startEdge = -100;
        freeEdge = 0;
        lastW = 1'b1;
        for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;
        modelMem[8'h30] = 32'h55;
        modelRd[0] = 32'h0;
        modelRd[1] = 32'h0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m]  = 1'b1;
                    pWe[m]   = 1'($urandom_range(0, 1));
                    pAddr[m] = 32'h80 + $urandom_range(0, 7);
                    pWd[m]   = $urandom;
                end
                applyStimulus(1'b1, m, pend[m], pWe[m], pAddr[m], pWd[m]);
            end
            if (k >= freeEdge && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = RR ? !lastW : 1'b0;
                else w = pend[1];
                lastW     = w;
                curOwner  = w;
                curWe     = pWe[w];
                curAddr   = pAddr[w];
                curWd     = pWd[w];
                startEdge = k;
                freeEdge  = k + WB + 3;
                pend[w]   = 1'b0;
            end
            tick();
            off = k - startEdge;
            active = (off >= 0) && (off <= WB + 1);
            if (active && off == WB + 1) begin
                if (curWe) modelMem[curAddr[7:0]] = curWd;
                else modelRd[curOwner] = modelMem[curAddr[7:0]];
            end
            expFlags = {active && off == 0 && !curOwner, active && off == 0 && curOwner,
                        active && off == WB + 1 && !curOwner, active && off == WB + 1 && curOwner,
                        active, active && off == WB && curWe};
            checkOutput($sformatf("rand.k%0d.flags", k), 32'(flagsB), 32'(expFlags));
            checkOutput($sformatf("rand.k%0d.addr", k), busB.ram_addr,
                        (active && off <= WB) ? curAddr : 32'h0);
            checkOutput($sformatf("rand.k%0d.wd", k), busB.ram_wd,
                        (active && off <= WB) ? curWd : 32'h0);
            checkOutput($sformatf("rand.k%0d.rd0", k), busB.m0_rdata, modelRd[0]);
            checkOutput($sformatf("rand.k%0d.rd1", k), busB.m1_rdata, modelRd[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two bus masters: m0 is the RISC-V core's memory-map path, and m1 is a second requester such as a DMA or UART engine.
- A 3-state FSM serialises the accesses, inserts programmable wait states, and returns per-master grant and done pulses plus read data.
- Sits between Mem_Map_Controler RAM-side signals (weRAM/AddrRAM/DataRAM/ReadRAM) and RAM_Single_Port, in the core clock domain.

Parameters:
- DATA_WIDTH, 32, width of the data bus.
- ADDR_WIDTH, 32, width of the address bus (passed through unchanged).
- WAIT_CYCLES, 0, extra cycles an access is held on the RAM port; legal range 0..15.

Ports:
- clk  in  1  system clock (core clock, e.g. clk_out).
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 access request (level).
- m0_we  in  1  m0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  m0 address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_gnt  out  1  one-cycle pulse: m0 request accepted.
- m0_done  out  1  one-cycle pulse: m0 access complete; m0_rdata valid on reads.
- m0_rdata  out  DATA_WIDTH  m0 read data, held until m0's next done.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: identical to the m0 set, for m1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wd  out  DATA_WIDTH  RAM write data.
- ram_rd  in  DATA_WIDTH  RAM read data (combinational read).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: ARB_IDLE, ARB_ACCESS, ARB_DONE.
- Reset (async, rst=1):
  - State goes to ARB_IDLE and last_winner goes to 1 immediately.
  - wait counter, latched we/addr/wdata/owner, and both rdata registers clear to 0.
  - All outputs read 0, including ram_we, which drops immediately.
- IDLE:
  - If any req is sampled high at a clock edge, pick a winner.
  - On that edge, latch the winner's we/addr/wdata and owner, load the wait counter with WAIT_CYCLES, and go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - mX_gnt is high for the owner in the first ACCESS cycle only.
  - ram_addr and ram_wd are driven from the latched registers for the whole state.
  - ram_we = latched_we AND (counter==0), so exactly one write cycle, the last cycle of ACCESS.
  - The counter decrements each cycle. When it is 0: capture ram_rd into the owner's rdata register (reads only; writes leave rdata unchanged), go to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- DONE:
  - mX_done is high for the owner for one cycle, then go to IDLE.
  - The non-owner's outputs remain 0.
- Outside ACCESS: ram_we=0, ram_addr=0, ram_wd=0.
- Latency: req sampled at edge N gives gnt in cycle N+1 and done in cycle N+2+WAIT_CYCLES. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles (includes the IDLE bubble).
- Handshake rules:
  - A master holds req, we, addr and wdata stable until it sees gnt.
  - Request inputs are ignored outside IDLE; the arbiter never drops a held req.
  - req still high at the IDLE after done is treated as a new request.
- Arbitration:
  - Both req high in IDLE: winner = NOT last_winner.
  - One req high: that master wins.
  - last_winner updates to the winner on every IDLE→ACCESS transition.
  - After reset, m0 wins the first tie.
- Widths:
  - Wait counter width is $clog2(WAIT_CYCLES+1), minimum 1.
  - Address and data pass through unmodified; no alignment checking.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, m0 always wins when both req are high. last_winner is not implemented, and m1 may starve.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_DONE}.
  - localparam MASTER_M0=1'b0, MASTER_M1=1'b1.
  - localparam MAX_WAIT_CYCLES=15.
- One sub-module: ram_arb_picker, holding the last_winner register and winner selection, including the macro switch.

Test Plan:
1. WAIT_CYCLES=0; m0 write addr 0x10 data 0xDEADBEEF at edge N.
   - Required: m0_gnt in N+1, ram_we high for exactly that one cycle, m0_done in N+2.
   - Then m0 read of 0x10 returns m0_rdata=0xDEADBEEF with m0_done.
2. Both req high from reset, each doing a read.
   - Round-robin (macro defined): order m0,m1,m0,m1; each gnt is 3 cycles apart.
   - Macro undefined: m0 is granted every transaction.
3. WAIT_CYCLES=3; m1 write of 0x55.
   - Required: ACCESS lasts 4 cycles, ram_we high only in the 4th, m1_done at gnt+4.
4. m1_req asserted while the m0 access is in ACCESS.
   - Required: m1 request ignored until IDLE, m1_gnt 2 cycles after m0_done.
   - m0_rdata unchanged by the m1 write.
5. rst asserted mid-ACCESS of a write with WAIT_CYCLES=3.
   - Required: ram_we, busy and gnt go 0 asynchronously, no done pulse, and RAM contents at the target address unchanged.
6. Idle with no req for 20 cycles.
   - Required: busy=0, ram_we=0, no gnt/done pulses.
